// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth signed multiplier: one Booth digit retired per clock,
// with valid/ready handshakes, exact 2*WIDTH product and a rounded, saturated Q-format result.
module booth_seq_mult #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] product,
  output logic signed [WIDTH-1:0]   q_result,
  output logic                      q_sat
);

  localparam int N     = WIDTH / 2;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0]   LAST_DIGIT = CNT_W'(N - 1);
  localparam logic signed [PW:0] ONE        = {{PW{1'b0}}, 1'b1};
  localparam logic signed [PW:0] HALF       = (ONE << FRAC) >> 1;
  localparam logic signed [PW:0] Q_MAX      = (ONE << (WIDTH - 1)) - ONE;
  localparam logic signed [PW:0] Q_MIN      = -(ONE << (WIDTH - 1));

  // HALF is zero when FRAC = 0, so the same expression covers the unscaled case.
  function automatic logic signed [PW:0] round_q(input logic signed [PW-1:0] p);
    logic signed [PW:0] pe;
    pe = {p[PW-1], p};
    return (pe + HALF) >>> FRAC;
  endfunction

  function automatic logic [WIDTH:0] sat_q(input logic signed [PW:0] t);
    if (t > Q_MAX)      return {1'b1, Q_MAX[WIDTH-1:0]};
    else if (t < Q_MIN) return {1'b1, Q_MIN[WIDTH-1:0]};
    else                return {1'b0, t[WIDTH-1:0]};
  endfunction

  logic [1:0]              state;
  logic signed [WIDTH-1:0] a_r;
  logic [WIDTH:0]          b_sh;
  logic [CNT_W-1:0]        idx;
  logic signed [PW-1:0]    acc;

  logic signed [WIDTH+1:0] pp_mag;
  logic                    pp_neg;
  logic signed [PW-1:0]    pp_ext;
  logic signed [PW-1:0]    pp_shift;
  logic signed [PW-1:0]    addend;
  logic signed [PW-1:0]    cin;
  logic signed [PW-1:0]    acc_nxt;
  logic [CNT_W:0]          shamt;

  // b_sh[2:0] is always {b[2i+1], b[2i], b[2i-1]} for the current digit i.
  always_comb begin
    pp_mag = '0;
    pp_neg = 1'b0;
    unique case (b_sh[2:0])
      3'b001, 3'b010: pp_mag = {{2{a_r[WIDTH-1]}}, a_r};
      3'b011:         pp_mag = {a_r[WIDTH-1], a_r, 1'b0};
      3'b100: begin
        pp_mag = {a_r[WIDTH-1], a_r, 1'b0};
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp_mag = {{2{a_r[WIDTH-1]}}, a_r};
        pp_neg = 1'b1;
      end
      default: begin
        pp_mag = '0;
        pp_neg = 1'b0;
      end
    endcase
    shamt    = {idx, 1'b0};
    pp_ext   = {{(PW-WIDTH-2){pp_mag[WIDTH+1]}}, pp_mag};
    pp_shift = pp_ext << shamt;
    // Negative digits: one's complement here, the +1 rides in as the carry-in.
    addend   = pp_neg ? ~pp_shift : pp_shift;
    cin      = {{(PW-1){1'b0}}, pp_neg};
    acc_nxt  = acc + addend + cin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      acc      <= '0;
      q_result <= '0;
      q_sat    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_sh  <= {b, 1'b0};
            acc   <= '0;
            idx   <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc  <= acc_nxt;
          b_sh <= b_sh >> 2;
          idx  <= idx + 1'b1;
          if (idx == LAST_DIGIT) begin
            {q_sat, q_result} <= sat_q(round_q(acc_nxt));
            state             <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign product   = acc;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult: four instances (8/0, 8/7, 8/1, 16/15) driven with directed and
// random operands; a monitor compares every DONE cycle against an arithmetic reference.
module tb_booth_seq_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int W_OF[4] = '{8, 8, 8, 16};
  int F_OF[4] = '{0, 7, 1, 15};

  logic [15:0] a_v[4];
  logic [15:0] b_v[4];
  logic        in_valid[4];
  logic        out_ready[4];
  logic        ir[4];
  logic        ov[4];
  logic        qs[4];
  logic [15:0] p0, p1, p2;
  logic [31:0] p3;
  logic [7:0]  q0, q1, q2;
  logic [15:0] q3;
  logic signed [63:0] prod_l[4];
  logic signed [63:0] q_l[4];

  assign prod_l[0] = 64'($signed(p0));
  assign prod_l[1] = 64'($signed(p1));
  assign prod_l[2] = 64'($signed(p2));
  assign prod_l[3] = 64'($signed(p3));
  assign q_l[0]    = 64'($signed(q0));
  assign q_l[1]    = 64'($signed(q1));
  assign q_l[2]    = 64'($signed(q2));
  assign q_l[3]    = 64'($signed(q3));

  booth_seq_mult #(.WIDTH(8), .FRAC(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .out_valid(ov[0]), .out_ready(out_ready[0]),
    .product(p0), .q_result(q0), .q_sat(qs[0]));
  booth_seq_mult #(.WIDTH(8), .FRAC(7)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .out_valid(ov[1]), .out_ready(out_ready[1]),
    .product(p1), .q_result(q1), .q_sat(qs[1]));
  booth_seq_mult #(.WIDTH(8), .FRAC(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(ir[2]),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .out_valid(ov[2]), .out_ready(out_ready[2]),
    .product(p2), .q_result(q2), .q_sat(qs[2]));
  booth_seq_mult #(.WIDTH(16), .FRAC(15)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(ir[3]),
    .a(a_v[3]), .b(b_v[3]), .out_valid(ov[3]), .out_ready(out_ready[3]),
    .product(p3), .q_result(q3), .q_sat(qs[3]));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  // Reference: plain integer product, then round-half-up scaling and clipping.
  function automatic void model(input int w, input int f, input longint av, input longint bv,
                                output longint p, output longint q, output longint s);
    longint t, mx, mn;
    p  = av * bv;
    t  = (f > 0) ? ((p + (64'sd1 <<< (f - 1))) >>> f) : p;
    mx = (64'sd1 <<< (w - 1)) - 1;
    mn = -(64'sd1 <<< (w - 1));
    if (t > mx)      begin q = mx; s = 1; end
    else if (t < mn) begin q = mn; s = 1; end
    else             begin q = t;  s = 0; end
  endfunction

  typedef struct { int k; longint a; longint b; longint c0; } op_t;
  op_t    pend[$];
  op_t    cur;
  bit     started = 1'b0;
  longint cyc = 0;
  longint ep, eq, es;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: tracks accepts, checks exclusivity, latency and held outputs every DONE cycle.
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      started = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) chk("ready_valid_excl", longint'(ir[k] & ov[k]), 0);
      if (pend.size() > 0) begin
        cur = pend[0];
        if (ov[cur.k]) begin
          if (!started) begin
            chk("latency", cyc - cur.c0, longint'(W_OF[cur.k] / 2));
            started = 1'b1;
          end
          model(W_OF[cur.k], F_OF[cur.k], cur.a, cur.b, ep, eq, es);
          chk("product", prod_l[cur.k], ep);
          chk("q_result", q_l[cur.k], eq);
          chk("q_sat", longint'(qs[cur.k]), es);
          if (out_ready[cur.k]) begin
            void'(pend.pop_front());
            started = 1'b0;
          end
        end else begin
          chk("in_ready_calc", longint'(ir[cur.k]), 0);
        end
      end
      for (int k = 0; k < 4; k++)
        if (in_valid[k] && ir[k])
          pend.push_back('{k, sx(longint'(a_v[k]), W_OF[k]), sx(longint'(b_v[k]), W_OF[k]), cyc + 1});
    end
  end

  task automatic do_op(input int k, input longint av, input longint bv, input int delay);
    int t;
    t = 0;
    while (!ir[k] && t < 50) begin @(posedge clk); #1; t++; end
    chk("idle_timeout", longint'(ir[k]), 1);
    a_v[k] = 16'(av);
    b_v[k] = 16'(bv);
    in_valid[k]  = 1'b1;
    out_ready[k] = (delay == 0);
    @(posedge clk); #1;
    t = 0;
    while (!ov[k] && t < 40) begin
      in_valid[k] = 1'($urandom_range(0, 1));
      a_v[k] = 16'($urandom);
      b_v[k] = 16'($urandom);
      @(posedge clk); #1;
      t++;
    end
    in_valid[k] = 1'b0;
    chk("done_timeout", longint'(ov[k]), 1);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      chk("in_ready_done", longint'(ir[k]), 0);
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    chk("out_valid_drop", longint'(ov[k]), 0);
  endtask

  function automatic int rnd_delay();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0;
  endfunction

  longint corner[8] = '{-128, -127, -64, -1, 0, 1, 63, 127};
  longint mp, mq, ms;

  initial begin
    for (int k = 0; k < 4; k++) begin
      a_v[k] = '0; b_v[k] = '0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rst_in_ready", longint'(ir[k]), 1);
      chk("rst_out_valid", longint'(ov[k]), 0);
      chk("rst_product", prod_l[k], 0);
      chk("rst_q_result", q_l[k], 0);
      chk("rst_q_sat", longint'(qs[k]), 0);
    end

    // Literal pins on the reference model.
    model(8, 0, 7, -3, mp, mq, ms);
    chk("model_7x-3_p", mp, -21); chk("model_7x-3_q", mq, -21); chk("model_7x-3_s", ms, 0);
    model(8, 0, -128, -128, mp, mq, ms);
    chk("model_min2_p", mp, 16384); chk("model_min2_q", mq, 127); chk("model_min2_s", ms, 1);
    model(8, 0, -128, 127, mp, mq, ms);
    chk("model_minmax_p", mp, -16256);
    model(8, 7, 64, 64, mp, mq, ms);
    chk("model_f7_p", mp, 4096); chk("model_f7_q", mq, 32); chk("model_f7_s", ms, 0);
    model(8, 1, 3, 1, mp, mq, ms);
    chk("model_f1_pos_q", mq, 2);
    model(8, 1, -3, 1, mp, mq, ms);
    chk("model_f1_neg_q", mq, -1);
    model(16, 15, -32768, -32768, mp, mq, ms);
    chk("model_w16_q", mq, 32767); chk("model_w16_s", ms, 1);

    // Directed operations.
    do_op(0, 7, -3, 0);
    chk("lit_7x-3_product", prod_l[0], -21);
    do_op(0, -128, -128, 0);
    chk("lit_min2_product", prod_l[0], 16384);
    chk("lit_min2_q", q_l[0], 127);
    do_op(0, -128, 127, 5);
    chk("lit_minmax_product", prod_l[0], -16256);
    do_op(1, 64, 64, 0);
    chk("lit_f7_q", q_l[1], 32);
    do_op(2, 3, 1, 2);
    chk("lit_f1_pos_q", q_l[2], 2);
    do_op(2, -3, 1, 0);
    chk("lit_f1_neg_q", q_l[2], -1);
    do_op(3, -32768, -32768, 0);

    // Reset during the second CALC cycle aborts; a following op must still be correct.
    @(posedge clk); #1;
    a_v[0] = 16'(100); b_v[0] = 16'(-77); in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", longint'(ir[0]), 1);
    chk("abort_out_valid", longint'(ov[0]), 0);
    chk("abort_product", prod_l[0], 0);
    out_ready[0] = 1'b0;
    do_op(0, -5, 9, 0);
    chk("post_abort_product", prod_l[0], -45);

    // Corner grid and random sweeps.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        do_op(0, corner[i], corner[j], 0);
    for (int i = 0; i < 1500; i++) do_op(0, sx(longint'($urandom), 8), sx(longint'($urandom), 8), rnd_delay());
    for (int i = 0; i < 300; i++)  do_op(1, sx(longint'($urandom), 8), sx(longint'($urandom), 8), rnd_delay());
    for (int i = 0; i < 300; i++)  do_op(2, sx(longint'($urandom), 8), sx(longint'($urandom), 8), rnd_delay());
    for (int i = 0; i < 2000; i++) do_op(3, sx(longint'($urandom), 16), sx(longint'($urandom), 16), rnd_delay());

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", longint'(pend.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
